// File: rtl/collision_if.sv
// Bundle between the cactus scroller/game shell and the collision detector.
// Detector consumes positions and start; produces game status.
interface collision_if;
  logic [10:0] s1;
  logic [10:0] s2;
  logic [10:0] s3;
  logic [10:0] s4;
  logic [10:0] s5;
  logic [10:0] s6;
  logic [9:0]  dino_y;
  logic        start;
  logic        freeze;
  logic        game_over;
  logic [2:0]  hit_idx;
  logic [13:0] score;
  logic [13:0] best;

  modport master (
    output s1, s2, s3, s4, s5, s6,
    output dino_y, start,
    input  freeze, game_over, hit_idx,
    input  score, best
  );

  modport slave (
    input  s1, s2, s3, s4, s5, s6,
    input  dino_y, start,
    output freeze, game_over, hit_idx,
    output score, best
  );
endinterface

// File: rtl/collision_detect.sv
// Dino-vs-cactus collision detector and game state machine.
// Tracks run score, best score and the cactus that ended the run.
module collision_detect #(
  parameter logic [10:0] DINO_X_L   = 11'd100,
  parameter logic [10:0] DINO_X_R   = 11'd140,
  parameter logic [10:0] CACTUS_W   = 11'd20,
  parameter logic [9:0]  CACTUS_H   = 10'd40,
  parameter logic [10:0] PARK_X     = 11'd640,
  parameter int          HIT_FRAMES = 2
) (
  input  logic        clk_16Hz,
  input  logic        rst_n,
  collision_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OVER
  } state_t;

  localparam logic [2:0]  HF_LAST   = 3'(HIT_FRAMES - 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  state_t      r_state;
  logic [2:0]  r_hit_cnt;
  logic [2:0]  r_hit_idx;
  logic [13:0] r_score;
  logic [13:0] r_best;
  logic        r_freeze;
  logic        r_over;

  state_t      w_state_nx;
  logic [2:0]  w_hit_cnt_nx;
  logic [2:0]  w_hit_idx_nx;
  logic [13:0] w_score_nx;
  logic [13:0] w_best_nx;
  logic [13:0] w_score_inc;

  logic [10:0] w_s [6];
  logic [5:0]  w_ov;
  logic        w_ov_any;
  logic [2:0]  w_lo;

  assign w_s[0] = bus.s1;
  assign w_s[1] = bus.s2;
  assign w_s[2] = bus.s3;
  assign w_s[3] = bus.s4;
  assign w_s[4] = bus.s5;
  assign w_s[5] = bus.s6;

  // Right-edge sum is widened so a far-right cactus cannot wrap into range.
  for (genvar g = 0; g < 6; g++) begin : g_ov
    logic [11:0] w_sum;
    assign w_sum   = {1'b0, w_s[g]} + {1'b0, CACTUS_W};
    assign w_ov[g] = (w_s[g] < PARK_X)
                  && (w_s[g] < DINO_X_R)
                  && (w_sum > {1'b0, DINO_X_L})
                  && (bus.dino_y < CACTUS_H);
  end

  assign w_ov_any = |w_ov;

  always_comb begin
    w_lo = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (w_ov[i]) w_lo = 3'(i + 1);
    end
  end

  assign w_score_inc = (r_score == SCORE_MAX) ? r_score
                     : r_score + 14'd1;

  always_comb begin
    w_state_nx   = r_state;
    w_hit_cnt_nx = r_hit_cnt;
    w_hit_idx_nx = r_hit_idx;
    w_score_nx   = r_score;
    w_best_nx    = r_best;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          w_state_nx   = S_RUN;
          w_hit_cnt_nx = 3'd0;
          w_hit_idx_nx = 3'd0;
          w_score_nx   = 14'd0;
        end
      end
      S_RUN: begin
        if (w_ov_any && (r_hit_cnt == HF_LAST)) begin
          w_state_nx   = S_OVER;
          w_hit_idx_nx = w_lo;
          if (r_score > r_best) w_best_nx = r_score;
        end else begin
          w_hit_cnt_nx = w_ov_any ? r_hit_cnt + 3'd1 : 3'd0;
          w_score_nx   = w_score_inc;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_16Hz) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hit_cnt <= 3'd0;
      r_hit_idx <= 3'd0;
      r_score   <= 14'd0;
      r_best    <= 14'd0;
      r_freeze  <= 1'b1;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_hit_cnt <= w_hit_cnt_nx;
      r_hit_idx <= w_hit_idx_nx;
      r_score   <= w_score_nx;
      r_best    <= w_best_nx;
      r_freeze  <= (w_state_nx != S_RUN);
      r_over    <= (w_state_nx == S_OVER);
    end
  end

  assign bus.freeze    = r_freeze;
  assign bus.game_over = r_over;
  assign bus.hit_idx   = r_hit_idx;
  assign bus.score     = r_score;
  assign bus.best      = r_best;

endmodule
